// File: rtl/pattern_ser_pkg.sv
// Shared types, default widths and helpers for the pattern serializer.
package pattern_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned PAT_W_DEF = 20;
    localparam int unsigned DIV_W_DEF = 16;
    localparam int unsigned RPT_W_DEF = 8;
    localparam int unsigned PAR_MAX_W = 64;

    // Even parity over a zero-extended pattern word.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/pattern_serializer_bit_timer.sv
// Loadable clocks-per-bit down-counter; flags the last cycle of a bit and
// pulses bit_stb on the first cycle after every load.
module pattern_serializer_bit_timer
    import pattern_ser_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic             tc_c,
    output logic             bit_stb
);

    logic [DIV_W-1:0] cnt_q;

    assign tc_c = (cnt_q == '0);

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            cnt_q   <= '0;
            bit_stb <= 1'b0;
        end else begin
            bit_stb <= load;
            if (load) begin
                cnt_q <= load_val;
            end else if (en && !tc_c) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_serializer.sv
// MSB-first pattern serializer with programmable bit time and frame repeats.
// Define PATTERN_SER_PARITY_EN to append an even-parity bit to every frame.
module pattern_serializer
    import pattern_ser_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF,
    parameter int unsigned RPT_W = RPT_W_DEF
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [DIV_W-1:0] div,
    input  logic [RPT_W-1:0] rpt,
    input  logic             abort,
    output logic             sdo,
    output logic             sdo_en,
    output logic             bit_stb,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [RPT_W-1:0] frame_q, frame_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ready_q;
    logic             accept;
    logic             tc;
    logic             tmr_load;
    logic [DIV_W-1:0] tmr_val;
    logic             frame_end;
    logic             sdo_d, sdo_en_d, frame_done_d, busy_d;
`ifdef PATTERN_SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // ready_q keeps the handshake closed while reset is asserted.
    assign pat_ready = ready_q && (state_q == IDLE) && !abort;
    assign accept    = pat_valid && pat_ready;

    pattern_serializer_bit_timer #(
        .DIV_W(DIV_W)
    ) u_bit_timer (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .load     (tmr_load),
        .en       (state_q == SHIFT),
        .load_val (tmr_val),
        .tc_c     (tc),
        .bit_stb  (bit_stb)
    );

    // Next-state, shadow capture and registered-output values.
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        div_d        = div_q;
        rpt_d        = rpt_q;
        frame_d      = frame_q;
        idx_d        = idx_q;
        tmr_load     = 1'b0;
        tmr_val      = div_q;
        frame_end    = 1'b0;
        frame_done_d = 1'b0;
`ifdef PATTERN_SER_PARITY_EN
        par_d        = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SHIFT;
                    pat_d    = pat_in;
                    div_d    = div;
                    rpt_d    = rpt;
                    frame_d  = '0;
                    idx_d    = IDX_TOP;
                    tmr_load = 1'b1;
                    tmr_val  = div;
`ifdef PATTERN_SER_PARITY_EN
                    par_d    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tc) begin
`ifdef PATTERN_SER_PARITY_EN
                    if (par_q) begin
                        frame_end = 1'b1;
                    end else if (idx_q == '0) begin
                        par_d    = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        idx_d    = idx_q - 1'b1;
                        tmr_load = 1'b1;
                    end
`else
                    if (idx_q == '0) begin
                        frame_end = 1'b1;
                    end else begin
                        idx_d    = idx_q - 1'b1;
                        tmr_load = 1'b1;
                    end
`endif
                    if (frame_end) begin
                        frame_done_d = 1'b1;
                        // frame_q only increments while below rpt_q, so it never wraps.
                        if (frame_q < rpt_q) begin
                            frame_d  = frame_q + 1'b1;
                            idx_d    = IDX_TOP;
                            tmr_load = 1'b1;
`ifdef PATTERN_SER_PARITY_EN
                            par_d    = 1'b0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d == SHIFT);
        sdo_en_d = busy_d;
        sdo_d    = busy_d ? pat_d[idx_d] : 1'b0;
`ifdef PATTERN_SER_PARITY_EN
        if (busy_d && par_d) begin
            sdo_d = even_parity(PAR_MAX_W'(pat_d));
        end
`endif
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            div_q      <= '0;
            rpt_q      <= '0;
            frame_q    <= '0;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            sdo        <= 1'b0;
            sdo_en     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
`ifdef PATTERN_SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            div_q      <= div_d;
            rpt_q      <= rpt_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            ready_q    <= 1'b1;
            sdo        <= sdo_d;
            sdo_en     <= sdo_en_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
`ifdef PATTERN_SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule
